// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

  localparam int StallBus    = 6;
  localparam int IF_TO_ID_WD = 33;
  localparam int BR_WD       = 33;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  // One word below the boot vector so the first fetch lands on 32'hBFC0_0000.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFBF_FFFC;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_redirect_buf.sv
// Holds a redirect that arrived while fetch was stalled and forms next_pc
// with priority: pending redirect, then live redirect, then sequential.
module fetch_redirect_buf
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_e,
  input  logic [31:0] br_addr,
  input  logic [31:0] pc_r,
  input  logic        capture,
  input  logic        consume,
  output logic        pend_v,
  output logic [31:0] pend_addr,
  output logic [31:0] next_pc,
  output logic        redirect
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v    <= 1'b0;
      pend_addr <= 32'b0;
    end else if (capture) begin
      pend_v    <= 1'b1;
      pend_addr <= br_addr;
    end else if (consume) begin
      pend_v    <= 1'b0;
    end
  end

  assign next_pc  = pend_v ? pend_addr : (br_e ? br_addr : pc_r + 32'd4);
  assign redirect = pend_v | br_e;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, boot/run/hold FSM and SRAM request.
// Optional performance counters are built only when FETCH_PERF_CNT_EN is defined.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [StallBus-1:0]    stall,
  input  logic [BR_WD-1:0]       br_bus,
  output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
  output logic                   inst_sram_en,
  output logic [3:0]             inst_sram_wen,
  output logic [31:0]            inst_sram_addr,
  output logic [31:0]            inst_sram_wdata,
  output logic [31:0]            fetch_cnt,
  output logic [31:0]            redirect_cnt
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_r, pc_d, next_pc, pend_addr;
  logic         ce_r, ce_d, load, capture, consume, pend_v, redirect;
  logic         br_e;
  logic [31:0]  br_addr;
  logic         unused_stall;

  assign br_e         = br_bus[32];
  assign br_addr      = br_bus[31:0];
  assign unused_stall = ^stall[StallBus-1:1];

  fetch_redirect_buf u_redirect_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .br_e      (br_e),
    .br_addr   (br_addr),
    .pc_r      (pc_r),
    .capture   (capture),
    .consume   (consume),
    .pend_v    (pend_v),
    .pend_addr (pend_addr),
    .next_pc   (next_pc),
    .redirect  (redirect)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_r    <= RESET_PC;
      ce_r    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_r    <= pc_d;
      ce_r    <= ce_d;
    end
  end

  // In HOLD the pending redirect always wins over a live br_e via next_pc priority.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_r;
    ce_d    = ce_r;
    load    = 1'b0;
    capture = 1'b0;
    case (state_q)
      BOOT: begin
        load    = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (stall[0] == Stop) begin
          if (br_e) begin
            capture = 1'b1;
            state_d = HOLD;
          end
        end else begin
          load = 1'b1;
        end
      end
      HOLD: begin
        if (stall[0] == Stop) begin
          capture = br_e;
        end else begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
    if (load) begin
      pc_d = next_pc;
      ce_d = 1'b1;
    end
  end

  assign consume = load & pend_v;

  assign if_to_id_bus    = {ce_r, pc_r};
  assign inst_sram_en    = ce_r;
  assign inst_sram_addr  = pc_r;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = 32'b0;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, redirect_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q    <= 32'b0;
      redirect_cnt_q <= 32'b0;
    end else begin
      if (ce_r && stall[0] == NoStop) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (load && redirect)          redirect_cnt_q <= redirect_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt    = fetch_cnt_q;
  assign redirect_cnt = redirect_cnt_q;
`else
  logic unused_redirect;
  assign unused_redirect = redirect;
  assign fetch_cnt       = 32'b0;
  assign redirect_cnt    = 32'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes expected fetch PCs,
// a negedge monitor pops and compares whenever the stage presents ce = 1.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] fetch_cnt;
  logic [31:0] redirect_cnt;

`ifdef FETCH_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  fetch_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .br_bus          (br_bus),
    .if_to_id_bus    (if_to_id_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .fetch_cnt       (fetch_cnt),
    .redirect_cnt    (redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          fetches_done = 0;
  int          redirs_done  = 0;
  int          pend_f = 0;
  int          pend_r = 0;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every cycle the stage presents a valid fetch, compare against the scoreboard.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n && inst_sram_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_fetch got %h want none", inst_sram_addr);
      end else begin
        e = exp_q.pop_front();
        chk("sram_addr", {1'b0, inst_sram_addr}, {1'b0, e});
        chk("if_to_id_bus", if_to_id_bus, {1'b1, e});
      end
    end
  end

  // One cycle: displayed pc_exp, with stall[0], br_e, br_addr driven; redir marks a redirect load.
  task automatic cyc(input logic [31:0] pc_exp, input logic st, input logic be,
                     input logic [31:0] ba, input logic redir);
    @(posedge clk);
    fetches_done += pend_f;
    redirs_done  += pend_r;
    #1;
    stall  = {5'b0, st};
    br_bus = {be, ba};
    exp_q.push_back(pc_exp);
    pend_f = st ? 0 : 1;
    pend_r = redir ? 1 : 0;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_fetch_cnt"}, {1'b0, fetch_cnt}, CNT_EN ? 33'(fetches_done) : 33'd0);
    chk({tag, "_redirect_cnt"}, {1'b0, redirect_cnt}, CNT_EN ? 33'(redirs_done) : 33'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    stall  = 6'b0;
    br_bus = 33'b0;
    repeat (2) @(negedge clk);
    chk("rst_en", {32'b0, inst_sram_en}, 33'd0);
    chk("rst_bus", if_to_id_bus, {1'b0, 32'hBFBF_FFFC});
    chk("wen", {29'b0, inst_sram_wen}, 33'd0);
    chk("wdata", {1'b0, inst_sram_wdata}, 33'd0);
    chk("rst_fetch_cnt", {1'b0, fetch_cnt}, 33'd0);
    chk("rst_redirect_cnt", {1'b0, redirect_cnt}, 33'd0);

    @(posedge clk);
    #1 rst_n = 1'b1;

    // Boot sequence and a one-cycle redirect
    cyc(32'hBFC0_0000, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(32'hBFC0_0004, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(32'hBFC0_0008, 1'b0, 1'b1, 32'h8000_0100, 1'b1);
    cyc(32'h8000_0100, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk_cnt("redir");

    // Stall with two redirects: the last one wins, a br_e at release is ignored
    cyc(32'h8000_0104, 1'b1, 1'b1, 32'h8000_0200, 1'b0);
    cyc(32'h8000_0104, 1'b1, 1'b1, 32'h8000_0300, 1'b0);
    cyc(32'h8000_0104, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(32'h8000_0104, 1'b0, 1'b1, 32'h8000_0400, 1'b1);
    cyc(32'h8000_0300, 1'b0, 1'b0, 32'h0, 1'b0);
    // Stall without redirect, then wrap past the top of memory and a misaligned target
    cyc(32'h8000_0304, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(32'h8000_0304, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(32'h8000_0308, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    cyc(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(32'h0000_0000, 1'b0, 1'b1, 32'h0000_0013, 1'b1);
    cyc(32'h0000_0013, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(32'h0000_0017, 1'b1, 1'b1, 32'h1234_5678, 1'b0);
    @(negedge clk);
    chk_cnt("mid");

    // Asynchronous reset in the middle of a HOLD cycle
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_en", {32'b0, inst_sram_en}, 33'd0);
    chk("async_bus", if_to_id_bus, {1'b0, 32'hBFBF_FFFC});
    chk("async_fetch_cnt", {1'b0, fetch_cnt}, 33'd0);
    chk("async_redirect_cnt", {1'b0, redirect_cnt}, 33'd0);
    stall        = 6'b0;
    br_bus       = 33'b0;
    fetches_done = 0;
    redirs_done  = 0;
    pend_f       = 0;
    pend_r       = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 100 sequential fetches from the boot vector; any leftover pending redirect would break the sequence
    for (int i = 0; i < 101; i++)
      cyc(32'hBFC0_0000 + 32'(4 * i), 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("run100_fetch_cnt", {1'b0, fetch_cnt}, CNT_EN ? 33'd100 : 33'd0);
    chk("run100_redirect_cnt", {1'b0, redirect_cnt}, 33'd0);

    #1;
    chk("scoreboard_empty", 33'(exp_q.size()), 33'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
